// File: rtl/rate_gen_pkg.sv
// Shared definitions for the rate_gen32 phase-accumulator rate generator.
package rate_gen_pkg;

  // Width of the phase accumulator and of the phase increment.
  localparam int ACC_W = 32;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    RUN    = 2'd2
  } state_e;

  // Reference clock rate expressed in 100 Hz units.
  function automatic logic [ACC_W-1:0] ref_100hz(input int unsigned mhz);
    return ACC_W'(mhz * 32'd10000);
  endfunction

endpackage

// File: rtl/rate_div_seq.sv
// Sequential restoring divider: 64-bit dividend / 32-bit divisor -> 32-bit
// quotient in exactly 32 iterations, one per cycle. The first iteration is
// performed on the start edge, and done pulses for one cycle after the last.
// The caller guarantees dividend[63:32] < divisor, so the upper 32 quotient
// bits are zero and only the lower 32 need to be developed.
module rate_div_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient
);

  // Partial remainder plus the register that shifts out remaining dividend
  // bits at the top while collecting quotient bits at the bottom.
  typedef struct packed {
    logic [31:0] rem;
    logic [31:0] quo;
  } div_st_t;

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  function automatic div_st_t div_step(input div_st_t s, input logic [31:0] d);
    div_st_t     r;
    logic [32:0] trial;
    logic [32:0] diff;
    logic        qbit;
    trial = {s.rem, s.quo[31]};
    diff  = trial - {1'b0, d};
    qbit  = (trial >= {1'b0, d});
    r.rem = qbit ? diff[31:0] : trial[31:0];
    r.quo = {s.quo[30:0], qbit};
    return r;
  endfunction

  div_st_t     st_q,   st_d;
  logic [31:0] dvs_q,  dvs_d;
  logic [4:0]  cnt_q,  cnt_d;
  logic        run_q,  run_d;
  logic        done_q, done_d;

  // Next-state for the iteration: load+first step on start, then 31 more steps.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    st_d   = st_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (start) begin
      st_d  = div_step(div_st_t'(dividend), divisor);
      dvs_d = divisor;
      cnt_d = 5'd31;
      run_d = 1'b1;
    end else if (run_q) begin
      st_d  = div_step(st_q, dvs_q);
      cnt_d = cnt_q - 5'd1;
      if (cnt_q == 5'd1) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Divider state registers; reset aborts any divide in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here is a plain flop (no memory array), so all of
    // them take the asynchronous reset.
    if (!rst_n) begin
      st_q   <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      st_q   <= st_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done     = done_q;
  assign quotient = st_q.quo;

endmodule

// File: rtl/rate_gen32.sv
// Programmable rate generator: a 32-bit phase accumulator whose increment is
// computed from a requested rate (100 Hz units) by a sequential divider.
// tick pulses once per output period; sq is the accumulator MSB, registered.
module rate_gen32
  import rate_gen_pkg::*;
#(
  parameter int CLKREF_RATE_IN_MHZ = 100
) (
  input  logic        clkref,
  input  logic        resetn,
  input  logic [31:0] rate_in,
  input  logic        rate_valid,
  output logic        rate_ready,
  output logic        tick,
  output logic        sq,
  output logic        busy,
  output logic        err,
  output logic [31:0] inc
);

  localparam logic [ACC_W-1:0] REF_100HZ = ref_100hz(CLKREF_RATE_IN_MHZ);
  // Rates at or above Nyquist of the reference are rejected.
  localparam logic [ACC_W-1:0] RATE_LIMIT = REF_100HZ >> 1;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q,   acc_d;
  logic [ACC_W-1:0] inc_q,   inc_d;
  logic             tick_q,  tick_d;
  logic             sq_q,    sq_d;
  logic             busy_q,  busy_d;
  logic             err_q,   err_d;
  logic             rdy_q,   rdy_d;

  logic             xfer;
  logic             rate_ok;
  logic             div_start;
  logic             div_done;
  logic [31:0]      div_quo;

  assign xfer    = rate_valid & rdy_q;
  assign rate_ok = (rate_in < RATE_LIMIT);

  // Increment = floor(rate_in * 2^32 / REF_100HZ); rate_ok keeps the
  // dividend's upper half below the divisor as the divider requires.
  rate_div_seq u_div (
    .clk      (clkref),
    .rst_n    (resetn),
    .start    (div_start),
    .dividend ({rate_in, 32'd0}),
    .divisor  (REF_100HZ),
    .done     (div_done),
    .quotient (div_quo)
  );

  // Control FSM: accept or reject rates, wait for the divider, load inc.
  always_comb begin
    state_d   = state_q;
    inc_d     = inc_q;
    err_d     = err_q;
    div_start = 1'b0;
    case (state_q)
      IDLE, RUN: begin
        if (xfer) begin
          if (rate_ok) begin
            err_d     = 1'b0;
            div_start = 1'b1;
            state_d   = DIVIDE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DIVIDE: begin
        if (div_done) begin
          inc_d   = div_quo;
          state_d = (div_quo != '0) ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: accumulator keeps running with the current inc in every state
  // (inc is zero in IDLE, so it holds there); phase is never cleared.
  always_comb begin
    {tick_d, acc_d} = {1'b0, acc_q} + {1'b0, inc_q};
    sq_d            = acc_q[ACC_W-1];
    busy_d          = (state_d == DIVIDE);
    rdy_d           = (state_d != DIVIDE);
  end

  // State and registered outputs.
  always_ff @(posedge clkref or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      acc_q   <= '0;
      inc_q   <= '0;
      tick_q  <= 1'b0;
      sq_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      inc_q   <= inc_d;
      tick_q  <= tick_d;
      sq_q    <= sq_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  assign rate_ready = rdy_q;
  assign tick       = tick_q;
  assign sq         = sq_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign inc        = inc_q;

endmodule

// File: tb/tb_rate_gen32.sv
// Self-checking bench for rate_gen32 at CLKREF_RATE_IN_MHZ = 100.
// A timeline model (acc as plain modular arithmetic, inc loaded 33 cycles
// after an accepted rate) is compared against the DUT every cycle, and
// directed steps pin hand-computed values.
module tb_rate_gen32;

  localparam longint REF   = 1000000;
  localparam longint TWO32 = 64'h1_0000_0000;

  logic        clkref = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] rate_in = '0;
  logic        rate_valid = 1'b0;
  logic        rate_ready, tick, sq, busy, err;
  logic [31:0] inc;

  rate_gen32 #(.CLKREF_RATE_IN_MHZ(100)) dut (
    .clkref     (clkref),
    .resetn     (resetn),
    .rate_in    (rate_in),
    .rate_valid (rate_valid),
    .rate_ready (rate_ready),
    .tick       (tick),
    .sq         (sq),
    .busy       (busy),
    .err        (err),
    .inc        (inc)
  );

  always #5 clkref = ~clkref;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_rng(input string name, input longint act,
                           input longint lo, input longint hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint m_acc, m_inc, m_pend, m_sum;
  int     m_left;
  bit     m_tick, m_sq, m_busy, m_rdy, m_err, m_xfer;

  always @(posedge clkref or negedge resetn) begin
    if (!resetn) begin
      m_acc = 0; m_inc = 0; m_pend = 0; m_left = 0;
      m_tick = 0; m_sq = 0; m_busy = 0; m_rdy = 0; m_err = 0;
    end else begin
      m_xfer = rate_valid && m_rdy;
      m_sum  = m_acc + m_inc;
      m_tick = (m_sum >= TWO32);
      m_sq   = m_acc[31];
      m_acc  = m_sum % TWO32;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_inc = m_pend;
      end
      if (m_xfer) begin
        if (longint'(rate_in) < REF / 2) begin
          m_err  = 0;
          m_left = 32;
          m_pend = (longint'(rate_in) * TWO32) / REF;
        end else begin
          m_err = 1;
        end
      end
      m_busy = (m_left > 0);
      m_rdy  = (m_left == 0);
    end
  end

  // Compare process: every cycle out of reset, away from the active edge.
  always @(negedge clkref) begin
    if (resetn) begin
      check("cyc_tick",  tick,       m_tick);
      check("cyc_sq",    sq,         m_sq);
      check("cyc_inc",   inc,        m_inc);
      check("cyc_busy",  busy,       m_busy);
      check("cyc_ready", rate_ready, m_rdy);
      check("cyc_err",   err,        m_err);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clkref);
    #1;
  endtask

  // One-cycle offer; ends one cycle after the transfer cycle.
  task automatic offer(input logic [31:0] r);
    check("ready_before_offer", rate_ready, 1);
    rate_in    = r;
    rate_valid = 1'b1;
    step(1);
    rate_valid = 1'b0;
  endtask

  int  n_tick, hi_run, rmin, rmax, sq_chg;
  bit  prev_sq, rose, sq0;

  task automatic count_window(input int n);
    n_tick = 0; hi_run = 0; rmin = 1000; rmax = 0; sq_chg = 0;
    prev_sq = sq; rose = 0;
    repeat (n) begin
      step(1);
      if (tick) n_tick++;
      if (sq != prev_sq) sq_chg++;
      if (sq) begin
        if (!prev_sq) rose = 1;
        hi_run++;
      end else begin
        if (prev_sq && rose) begin
          if (hi_run < rmin) rmin = hi_run;
          if (hi_run > rmax) rmax = hi_run;
        end
        hi_run = 0;
      end
      prev_sq = sq;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #1;
    check("rst_ready", rate_ready, 0);
    check("rst_tick",  tick, 0);
    check("rst_sq",    sq, 0);
    check("rst_busy",  busy, 0);
    check("rst_err",   err, 0);
    check("rst_inc",   inc, 0);
    step(3);
    resetn = 1'b1;
    #1;
    check("ready_before_first_edge", rate_ready, 0);
    step(1);
    check("ready_first_edge", rate_ready, 1);
    check("inc_after_reset", inc, 0);

    // 400000 -> inc 1717986918, 40% of cycles tick
    offer(32'd400000);
    check("busy_first_div_cycle", busy, 1);
    step(31);
    check("inc_old_at_32", inc, 0);
    check("busy_last_div_cycle", busy, 1);
    step(1);
    check("inc_400k_at_33", inc, 1717986918);
    check("busy_fall_33", busy, 0);
    count_window(20000);
    check_rng("ticks_400k", n_tick, 7999, 8001);

    // 10000 -> inc 42949672, 1% of cycles tick, 50/50 square wave
    offer(32'd10000);
    step(32);
    check("inc_10k", inc, 42949672);
    count_window(20000);
    check_rng("ticks_10k", n_tick, 199, 201);
    check_rng("sq_hi_min", rmin, 49, 51);
    check_rng("sq_hi_max", rmax, 49, 51);

    // exactly REF/2 is rejected; next valid rate clears err
    offer(32'd500000);
    check("err_reject", err, 1);
    check("inc_kept", inc, 42949672);
    check("ready_kept", rate_ready, 1);
    check("busy_not_started", busy, 0);
    step(5);
    offer(32'd20000);
    check("err_cleared", err, 0);
    step(32);
    check("inc_20k", inc, 85899345);

    // rate 0 -> back to IDLE, accumulator frozen
    offer(32'd0);
    step(32);
    check("inc_zero", inc, 0);
    check("ready_idle", rate_ready, 1);
    step(2);
    sq0 = sq;
    count_window(10000);
    check("ticks_zero", n_tick, 0);
    check("sq_frozen_changes", sq_chg, 0);
    check("sq_frozen_level", sq, sq0);

    // second rate held through DIVIDE, accepted on the load cycle
    rate_in    = 32'd10000;
    rate_valid = 1'b1;
    step(1);
    rate_in = 32'd30000;
    check("stall_busy", busy, 1);
    check("stall_ready", rate_ready, 0);
    step(32);
    check("load_cycle_ready", rate_ready, 1);
    check("load_cycle_inc", inc, 42949672);
    step(1);
    rate_valid = 1'b0;
    check("second_accepted", busy, 1);
    step(32);
    check("inc_30k", inc, 128849018);

    // reset in the 10th DIVIDE cycle
    offer(32'd400000);
    step(9);
    check("busy_before_reset", busy, 1);
    #2;
    resetn = 1'b0;
    #1;
    check("ar_ready", rate_ready, 0);
    check("ar_tick",  tick, 0);
    check("ar_sq",    sq, 0);
    check("ar_busy",  busy, 0);
    check("ar_err",   err, 0);
    check("ar_inc",   inc, 0);
    step(2);
    resetn = 1'b1;
    step(1);
    check("post_rst_ready", rate_ready, 1);
    check("post_rst_inc", inc, 0);
    step(40);
    check("aborted_no_load", inc, 0);
    check("aborted_no_tick_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
